// File: rtl/rf_cmd_ctrl.sv
// UART-to-register-file command controller: decodes write (CMD,ADDR,DATA) and read (CMD,ADDR) frames.
// Optional inter-byte timeout is compiled in with `define RF_CMD_TIMEOUT_EN.
module rf_cmd_ctrl #(
    parameter int                    DATA_WIDTH     = 8,
    parameter int                    REG_FILE_DEPTH = 16,
    parameter int                    ADDR_WIDTH     = $clog2(REG_FILE_DEPTH),
    parameter logic [DATA_WIDTH-1:0] WR_CMD         = 8'hAA,
    parameter logic [DATA_WIDTH-1:0] RD_CMD         = 8'hBB,
    parameter int                    TIMEOUT_CYCLES = 1024
) (
    input  logic                  CLK,
    input  logic                  RST_n,
    input  logic [DATA_WIDTH-1:0] RX_P_DATA,
    input  logic                  RX_D_VLD,
    input  logic [DATA_WIDTH-1:0] RdData,
    input  logic                  RdData_valid,
    input  logic                  TX_Busy,
    output logic                  WrEn,
    output logic                  RdEn,
    output logic [ADDR_WIDTH-1:0] Address,
    output logic [DATA_WIDTH-1:0] WrData,
    output logic [DATA_WIDTH-1:0] TX_P_DATA,
    output logic                  TX_D_VLD,
    output logic                  Cmd_Err
);

    localparam int unsigned DEPTH_U = REG_FILE_DEPTH;

    if (TIMEOUT_CYCLES < 2 || REG_FILE_DEPTH > (1 << ADDR_WIDTH)) begin : g_bad_cfg
        $error("rf_cmd_ctrl: inconsistent parameter set");
    end

    typedef enum logic [2:0] {
        IDLE,
        WR_ADDR,
        WR_DATA,
        RD_ADDR,
        RD_WAIT,
        TX_SEND
    } state_t;

    state_t state, state_nxt;

    logic                  addr_ok;
    logic                  abort;
    logic                  wr_en_d, rd_en_d, tx_vld_d, err_d;
    logic [ADDR_WIDTH-1:0] addr_d;
    logic [DATA_WIDTH-1:0] wdata_d, tx_data_d;

    always_comb begin
        addr_ok = (32'(RX_P_DATA) < DEPTH_U);
    end

`ifdef RF_CMD_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt;
    logic          timed;
    logic          rd_done;

    always_comb begin
        timed   = (state == WR_ADDR) || (state == WR_DATA) ||
                  (state == RD_ADDR) || (state == RD_WAIT);
        rd_done = (state == RD_WAIT) && RdData_valid;
        // fires on the edge where the count would reach TIMEOUT_CYCLES; an arriving byte wins
        abort   = timed && !RX_D_VLD && !rd_done && (cnt == CW'(TIMEOUT_CYCLES - 1));
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            cnt <= '0;
        end else if (!timed || RX_D_VLD || (state != state_nxt)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end
`else
    always_comb begin
        abort = 1'b0;
    end
`endif

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (RX_D_VLD) begin
                        if (RX_P_DATA == WR_CMD)      state_nxt = WR_ADDR;
                        else if (RX_P_DATA == RD_CMD) state_nxt = RD_ADDR;
                    end
                end
                WR_ADDR: if (RX_D_VLD) state_nxt = addr_ok ? WR_DATA : IDLE;
                WR_DATA: if (RX_D_VLD) state_nxt = IDLE;
                RD_ADDR: if (RX_D_VLD) state_nxt = addr_ok ? RD_WAIT : IDLE;
                RD_WAIT: if (RdData_valid) state_nxt = TX_SEND;
                TX_SEND: if (!TX_Busy) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        wr_en_d   = 1'b0;
        rd_en_d   = 1'b0;
        tx_vld_d  = 1'b0;
        err_d     = abort;
        addr_d    = Address;
        wdata_d   = WrData;
        tx_data_d = TX_P_DATA;
        case (state)
            IDLE: begin
                if (RX_D_VLD && (RX_P_DATA != WR_CMD) && (RX_P_DATA != RD_CMD)) err_d = 1'b1;
            end
            WR_ADDR: begin
                if (RX_D_VLD) begin
                    if (addr_ok) addr_d = RX_P_DATA[ADDR_WIDTH-1:0];
                    else         err_d  = 1'b1;
                end
            end
            WR_DATA: begin
                if (RX_D_VLD) begin
                    wdata_d = RX_P_DATA;
                    wr_en_d = 1'b1;
                end
            end
            RD_ADDR: begin
                if (RX_D_VLD) begin
                    if (addr_ok) begin
                        addr_d  = RX_P_DATA[ADDR_WIDTH-1:0];
                        rd_en_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            RD_WAIT: begin
                if (RX_D_VLD)     err_d     = 1'b1;
                if (RdData_valid) tx_data_d = RdData;
            end
            TX_SEND: begin
                if (RX_D_VLD) err_d    = 1'b1;
                if (!TX_Busy) tx_vld_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            WrEn      <= 1'b0;
            RdEn      <= 1'b0;
            Address   <= '0;
            WrData    <= '0;
            TX_P_DATA <= '0;
            TX_D_VLD  <= 1'b0;
            Cmd_Err   <= 1'b0;
        end else begin
            WrEn      <= wr_en_d;
            RdEn      <= rd_en_d;
            Address   <= addr_d;
            WrData    <= wdata_d;
            TX_P_DATA <= tx_data_d;
            TX_D_VLD  <= tx_vld_d;
            Cmd_Err   <= err_d;
        end
    end

endmodule

// File: tb/tb_rf_cmd_ctrl.sv
// Self-checking bench for rf_cmd_ctrl: frame-level reference model, directed scenarios, random traffic.
// Honours `define RF_CMD_TIMEOUT_EN (timeout of 16 cycles).
module tb_rf_cmd_ctrl;

    localparam int TO = 16;

    logic       CLK = 1'b0;
    logic       RST_n;
    logic [7:0] RX_P_DATA;
    logic       RX_D_VLD;
    logic [7:0] RdData;
    logic       RdData_valid;
    logic       TX_Busy;
    logic       WrEn, RdEn, TX_D_VLD, Cmd_Err;
    logic [3:0] Address;
    logic [7:0] WrData, TX_P_DATA;

    rf_cmd_ctrl #(
        .DATA_WIDTH    (8),
        .REG_FILE_DEPTH(16),
        .WR_CMD        (8'hAA),
        .RD_CMD        (8'hBB),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .CLK         (CLK),
        .RST_n       (RST_n),
        .RX_P_DATA   (RX_P_DATA),
        .RX_D_VLD    (RX_D_VLD),
        .RdData      (RdData),
        .RdData_valid(RdData_valid),
        .TX_Busy     (TX_Busy),
        .WrEn        (WrEn),
        .RdEn        (RdEn),
        .Address     (Address),
        .WrData      (WrData),
        .TX_P_DATA   (TX_P_DATA),
        .TX_D_VLD    (TX_D_VLD),
        .Cmd_Err     (Cmd_Err)
    );

    always #5 CLK = ~CLK;

    int vectors    = 0;
    int miscompares = 0;
    int rd_pulses  = 0;

    // register-file stand-in driven by the DUT's strobes
    logic [7:0] mem [16];

    // reference model: accepted frame bytes plus read-in-flight flags
    logic [7:0] frame [$];
    bit         rd_wait, tx_pend;
    int         quiet;
    logic       e_wr, e_rd, e_txv, e_err;
    logic [3:0] e_addr;
    logic [7:0] e_wdata, e_tx;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit busy, timed, progressed;
        if (!RST_n) begin
            {e_wr, e_rd, e_txv, e_err} = '0;
            e_addr = '0; e_wdata = '0; e_tx = '0;
            frame.delete(); rd_wait = 0; tx_pend = 0; quiet = 0;
            return;
        end
        busy       = rd_wait || tx_pend;
        timed      = (frame.size() > 0) || rd_wait;
        progressed = 0;
        {e_wr, e_rd, e_txv, e_err} = '0;
        if (tx_pend) begin
            if (!TX_Busy) begin e_txv = 1; tx_pend = 0; end
        end else if (rd_wait && RdData_valid) begin
            e_tx = RdData; rd_wait = 0; tx_pend = 1; progressed = 1;
        end
        if (RX_D_VLD) begin
            if (busy) begin
                e_err = 1;
            end else if (frame.size() == 0) begin
                if (RX_P_DATA == 8'hAA || RX_P_DATA == 8'hBB) frame.push_back(RX_P_DATA);
                else e_err = 1;
            end else if (frame.size() == 1) begin
                if (RX_P_DATA < 16) begin
                    e_addr = RX_P_DATA[3:0];
                    if (frame[0] == 8'hBB) begin
                        e_rd = 1; rd_wait = 1; frame.delete();
                    end else begin
                        frame.push_back(RX_P_DATA);
                    end
                end else begin
                    e_err = 1; frame.delete();
                end
            end else begin
                e_wdata = RX_P_DATA; e_wr = 1; frame.delete();
            end
        end
`ifdef RF_CMD_TIMEOUT_EN
        if (!timed || RX_D_VLD || progressed) begin
            quiet = 0;
        end else begin
            quiet++;
            if (quiet == TO) begin
                e_err = 1; frame.delete(); rd_wait = 0; quiet = 0;
            end
        end
`else
        quiet = timed ? quiet + 1 : 0;
`endif
    endtask

    // one clock: predict, clock, compare, then let the register file respond
    task automatic cycle();
        model_step();
        @(posedge CLK);
        #1;
        chk("WrEn", 32'(WrEn), 32'(e_wr));
        chk("RdEn", 32'(RdEn), 32'(e_rd));
        chk("Address", 32'(Address), 32'(e_addr));
        chk("WrData", 32'(WrData), 32'(e_wdata));
        chk("TX_P_DATA", 32'(TX_P_DATA), 32'(e_tx));
        chk("TX_D_VLD", 32'(TX_D_VLD), 32'(e_txv));
        chk("Cmd_Err", 32'(Cmd_Err), 32'(e_err));
        chk("wr_rd_exclusive", 32'(WrEn & RdEn), 32'd0);
        if (RdEn) rd_pulses++;
        if (WrEn) mem[Address] = WrData;
        RdData_valid = RdEn;
        RdData       = RdEn ? mem[Address] : 8'h00;
        RX_D_VLD     = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        RX_P_DATA = b;
        RX_D_VLD  = 1'b1;
        cycle();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic wait_tx(input string name, input int budget, input logic [7:0] exp);
        int n = 0;
        while (!TX_D_VLD && n < budget) begin
            cycle();
            n++;
        end
        chk({name, "_tx_seen"}, 32'(TX_D_VLD), 32'd1);
        chk({name, "_tx_data"}, 32'(TX_P_DATA), 32'(exp));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int start;
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        RST_n = 1'b0; RX_P_DATA = '0; RX_D_VLD = 0; RdData = '0; RdData_valid = 0; TX_Busy = 0;
        idle(3);
        chk("reset_outputs", 32'({WrEn, RdEn, Address, WrData, TX_P_DATA, TX_D_VLD, Cmd_Err}), 32'd0);
        RST_n = 1'b1;
        idle(2);

        // reset in the middle of a write frame
        send(8'hAA);
        send(8'h07);
        RST_n = 1'b0;
        #1;
        chk("async_reset_addr", 32'(Address), 32'd0);
        RX_P_DATA = 8'h3C; RX_D_VLD = 1'b1;
        cycle();
        chk("reset_no_wren", 32'(WrEn), 32'd0);
        RST_n = 1'b1;
        idle(2);
        send(8'hAA); send(8'h05); send(8'h3C);
        chk("t1_wren", 32'(WrEn), 32'd1);
        chk("t1_addr", 32'(Address), 32'd5);
        chk("t1_wdata", 32'(WrData), 32'h3C);
        cycle();
        chk("t1_wren_one_cycle", 32'(WrEn), 32'd0);

        // plain read
        rd_pulses = 0;
        send(8'hBB); send(8'h05);
        chk("t2_rden", 32'(RdEn), 32'd1);
        wait_tx("t2", 10, 8'h3C);
        idle(2);
        chk("t2_one_rden", 32'(rd_pulses), 32'd1);

        // read held off by a busy transmitter
        send(8'hAA); send(8'h02); send(8'h81);
        TX_Busy = 1'b1;
        send(8'hBB); send(8'h02);
        cycle();
        for (int i = 0; i < 20; i++) begin
            if (i == 5) begin
                send(8'hAA);
                chk("t3_drop_err", 32'(Cmd_Err), 32'd1);
            end else begin
                cycle();
            end
            chk("t3_hold", 32'(TX_P_DATA), 32'h81);
            chk("t3_no_vld", 32'(TX_D_VLD), 32'd0);
        end
        TX_Busy = 1'b0;
        cycle();
        chk("t3_vld", 32'(TX_D_VLD), 32'd1);
        chk("t3_data", 32'(TX_P_DATA), 32'h81);
        idle(2);

        // bad opcode and out-of-range address
        send(8'h11);
        chk("t4_bad_cmd", 32'(Cmd_Err), 32'd1);
        chk("t4_no_strobe", 32'(WrEn | RdEn), 32'd0);
        cycle();
        chk("t4_err_pulse", 32'(Cmd_Err), 32'd0);
        send(8'hAA); send(8'h10);
        chk("t4_bad_addr", 32'(Cmd_Err), 32'd1);
        send(8'h3C);
        chk("t4_back_in_idle", 32'(Cmd_Err), 32'd1);
        chk("t4_no_wren", 32'(WrEn), 32'd0);
        idle(2);

        // back-to-back frames
        send(8'hAA); send(8'h0F); send(8'hFF);
        chk("t5_wren", 32'(WrEn), 32'd1);
        chk("t5_addr", 32'(Address), 32'd15);
        chk("t5_wdata", 32'(WrData), 32'hFF);
        send(8'hBB); send(8'h0F);
        chk("t5_rden", 32'(RdEn), 32'd1);
        wait_tx("t5", 10, 8'hFF);
        idle(2);

        // silence mid-frame
        send(8'hAA); send(8'h03);
`ifdef RF_CMD_TIMEOUT_EN
        for (int i = 1; i < TO; i++) begin
            cycle();
            chk("t6_no_early_err", 32'(Cmd_Err), 32'd0);
        end
        cycle();
        chk("t6_timeout_err", 32'(Cmd_Err), 32'd1);
        idle(2);
        send(8'hAA); send(8'h03); send(8'h77);
`else
        idle(3 * TO);
        chk("t6_still_waiting", 32'(Cmd_Err), 32'd0);
        send(8'h77);
`endif
        chk("t6_wren", 32'(WrEn), 32'd1);
        chk("t6_addr", 32'(Address), 32'd3);
        chk("t6_wdata", 32'(WrData), 32'h77);
        idle(2);

        // random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            int r;
            if ($urandom_range(0, 199) == 0) begin
                TX_Busy = 1'b0;
                idle(TO + 4);
            end else if ($urandom_range(0, 599) == 0) begin
                RST_n = 1'b0;
                idle(2);
                RST_n = 1'b1;
            end else begin
                r = $urandom_range(0, 9);
                if (r < 3)      RX_P_DATA = 8'hAA;
                else if (r < 6) RX_P_DATA = 8'hBB;
                else if (r < 9) RX_P_DATA = 8'($urandom_range(0, 20));
                else            RX_P_DATA = 8'($urandom_range(0, 255));
                RX_D_VLD = ($urandom_range(0, 9) < 5);
                TX_Busy  = ($urandom_range(0, 3) == 0);
                cycle();
            end
        end
        TX_Busy = 1'b0;
        start = vectors;
        idle(4);
        chk("random_ran", 32'(vectors > start), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
